apb_master: RTL

- APB requester bridge that sits directly upstream of the team's APB slave peripherals.
- Converts a simple valid/ready command interface (one read or write per command) into a compliant APB SETUP/ACCESS transfer.
- Returns read data, slave error and a timeout flag on a valid/ready response interface.
- Drives PSEL/PENABLE/PWRITE/PADDR/PWDATA; consumes PREADY/PRDATA/PSLVERR.

---
 rtl/apb_pkg.sv | 25 ++
 rtl/apb_master_if.sv | 51 +++++
 rtl/apb_master.sv | 125 ++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester bridge and its bench.
package apb_pkg;

    // Timeout applied when the instantiating block does not override it.
    localparam int DEFAULT_TIMEOUT = 16;

    // Widest data bus a response record can carry.
    localparam int MAX_DATA_WIDTH = 32;

    // Transfer sequencing: one command walks IDLE -> SETUP -> ACCESS -> RESP.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10,
        RESP   = 2'b11
    } apb_master_state_t;

    // Everything a consumer learns about a finished transfer.
    typedef struct packed {
        logic [MAX_DATA_WIDTH-1:0] rdata;
        logic                      err;
        logic                      timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_master_if.sv
// Command, response and APB bus signals of the requester bridge.
// The master modport is the bridge's view; slave is the view of whatever
// sits around it (command source, response sink and APB peripheral).
interface apb_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8
);

    // Command channel
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_write_i;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic [DATA_WIDTH-1:0] cmd_wdata_i;

    // Response channel
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic                  rsp_err_o;
    logic                  rsp_timeout_o;

    // APB bus
    logic                  PSEL_o;
    logic                  PENABLE_o;
    logic                  PWRITE_o;
    logic [ADDR_WIDTH-1:0] PADDR_o;
    logic [DATA_WIDTH-1:0] PWDATA_o;
    logic                  PREADY_i;
    logic [DATA_WIDTH-1:0] PRDATA_i;
    logic                  PSLVERR_i;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        input  rsp_ready_i,
        output PSEL_o, PENABLE_o, PWRITE_o, PADDR_o, PWDATA_o,
        input  PREADY_i, PRDATA_i, PSLVERR_i
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        output rsp_ready_i,
        input  PSEL_o, PENABLE_o, PWRITE_o, PADDR_o, PWDATA_o,
        output PREADY_i, PRDATA_i, PSLVERR_i
    );

endinterface

// File: rtl/apb_master.sv
// APB requester bridge: turns one valid/ready command into one APB
// SETUP/ACCESS transfer and returns the outcome on a valid/ready response
// channel. Transfers never overlap; a stalled slave is abandoned after
// TIMEOUT_CYCLES consecutive not-ready ACCESS cycles.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic              PCLK,
    input  logic              PPRESETn,
    apb_master_if.master      bus
);

    // Counter must be able to hold TIMEOUT_CYCLES itself.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    apb_master_state_t     state;
    logic [CNT_W-1:0]      wait_cnt;

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    // Transfer sequencer: state, APB drive, wait counter and response capture.
    // NOTE: every register here uses non-blocking assignment and is cleared by
    // the asynchronous reset, so PSEL/PENABLE drop the moment PPRESETn falls
    // and a pending response is discarded without waiting for a clock.
    always_ff @(posedge PCLK or negedge PPRESETn) begin
        if (!PPRESETn) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid_i) begin
                        pwrite  <= bus.cmd_write_i;
                        paddr   <= bus.cmd_addr_i;
                        pwdata  <= bus.cmd_write_i ? bus.cmd_wdata_i : '0;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        state   <= SETUP;
                    end
                end

                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end

                ACCESS: begin
                    if (bus.PREADY_i) begin
                        // Completion beats a timeout that would fire this cycle.
                        rsp_rdata   <= pwrite ? '0 : bus.PRDATA_i;
                        rsp_err     <= bus.PSLVERR_i;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        state       <= RESP;
                    end else if (wait_cnt == LAST_WAIT) begin
                        // This is the last tolerated not-ready cycle: abandon.
                        wait_cnt    <= CNT_LIMIT;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                RESP: begin
                    if (bus.rsp_ready_i) begin
                        rsp_valid <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Commands are only taken while no transfer is in flight.
    assign bus.cmd_ready_o   = (state == IDLE);

    assign bus.rsp_valid_o   = rsp_valid;
    assign bus.rsp_rdata_o   = rsp_rdata;
    assign bus.rsp_err_o     = rsp_err;
    assign bus.rsp_timeout_o = rsp_timeout;

    assign bus.PSEL_o        = psel;
    assign bus.PENABLE_o     = penable;
    assign bus.PWRITE_o      = pwrite;
    assign bus.PADDR_o       = paddr;
    assign bus.PWDATA_o      = pwdata;

endmodule
